// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU issue stage and its register file.
package alu_pkg;

    localparam int unsigned W    = 4;
    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = $clog2(NREG);

    typedef logic [W-1:0]  data_t;
    typedef logic [AW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } issue_state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREG x W register file: one write port, two operand read ports, one debug read port.
module alu_regfile
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     we,
    input  reg_idx_t waddr,
    input  data_t    wdata,
    input  reg_idx_t raddr_a,
    output data_t    rdata_a,
    input  reg_idx_t raddr_b,
    output data_t    rdata_b,
    input  reg_idx_t dbg_addr,
    output data_t    dbg_data
);

    data_t mem_q [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem_q[raddr_a];
    assign rdata_b  = mem_q[raddr_b];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 4-bit ALU: IDLE -> EXEC -> WB, one instruction in flight,
// operands read from the internal register file and the result written back.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    output logic     in_ready,
    input  logic     in_op,
    input  reg_idx_t in_rd,
    input  reg_idx_t in_rs1,
    input  reg_idx_t in_rs2,
    input  logic     load_valid,
    input  reg_idx_t load_addr,
    input  data_t    load_data,
    output logic     load_ready,
    output data_t    alu_a,
    output data_t    alu_b,
    output logic     alu_select,
    input  data_t    alu_out,
    input  logic     alu_zero,
    output logic     done,
    output data_t    result,
    output logic     zero_flag,
    input  reg_idx_t dbg_addr,
    output data_t    dbg_data
);

    issue_state_e state_q, state_d;
    reg_idx_t     rd_q, rd_d;
    data_t        a_q, a_d;
    data_t        b_q, b_d;
    logic         sel_q, sel_d;
    logic         done_q, done_d;
    data_t        result_q, result_d;
    logic         zero_q, zero_d;

    logic     rf_we;
    reg_idx_t rf_waddr;
    data_t    rf_wdata;
    data_t    rs1_data;
    data_t    rs2_data;

    alu_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr_a  (in_rs1),
        .rdata_a  (rs1_data),
        .raddr_b  (in_rs2),
        .rdata_b  (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        done_d     = 1'b0;
        result_d   = result_q;
        zero_d     = zero_q;
        rf_we      = 1'b0;
        rf_waddr   = load_addr;
        rf_wdata   = load_data;
        in_ready   = 1'b0;
        load_ready = 1'b0;

        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                in_ready   = !load_valid;
                // A load blocks acceptance in the same cycle, so the two never collide.
                if (load_valid) begin
                    rf_we = 1'b1;
                end else if (in_valid) begin
                    rd_d    = in_rd;
                    a_d     = rs1_data;
                    b_d     = rs2_data;
                    sel_d   = in_op;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = alu_out;
                result_d = alu_out;
                zero_d   = alu_zero;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_select = sel_q;
    assign done       = done_q;
    assign result     = result_q;
    assign zero_flag  = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized scoreboard bench for alu_issue_ctrl with a behavioural 4-bit ALU beside it.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    typedef struct {
        data_t res;
        logic  z;
    } exp_t;

    logic     clk = 1'b0;
    logic     reset;
    logic     in_valid, in_ready, in_op;
    reg_idx_t in_rd, in_rs1, in_rs2;
    logic     load_valid, load_ready;
    reg_idx_t load_addr;
    data_t    load_data;
    data_t    alu_a, alu_b, alu_out;
    logic     alu_select, alu_zero;
    logic     done;
    data_t    result;
    logic     zero_flag;
    reg_idx_t dbg_addr;
    data_t    dbg_data;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_issued = 0;
    int   n_done   = 0;
    exp_t exp_q[$];
    data_t model[NREG];
    data_t last_res = '0;
    logic  last_z   = 1'b0;

    always #5 clk = ~clk;

    // ALU stand-in: SELECT=1 adds, SELECT=0 subtracts, both modulo 2^W.
    assign alu_out  = alu_select ? data_t'(alu_a + alu_b) : data_t'(alu_a - alu_b);
    assign alu_zero = (alu_out == '0);

    alu_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .done       (done),
        .result     (result),
        .zero_flag  (zero_flag),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on every done pulse; between pulses the outputs must hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_result", 32'(result), 32'(e.res));
                    chk("wb_zero", 32'(zero_flag), 32'(e.z));
                    last_res = e.res;
                    last_z   = e.z;
                end
            end else begin
                chk("result_hold", 32'(result), 32'(last_res));
                chk("zero_hold", 32'(zero_flag), 32'(last_z));
            end
        end
    end

    task automatic check_reg(input reg_idx_t a);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), 32'(dbg_data), 32'(model[a]));
    endtask

    // Called just after a negedge while the DUT is idle.
    task automatic do_load(input reg_idx_t a, input data_t d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        #1;
        chk("load_ready_idle", 32'(load_ready), 32'(1));
        @(posedge clk);
        model[a] = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Holds in_valid through EXEC and WB; optionally pokes an illegal load during EXEC.
    task automatic issue(input logic op, input reg_idx_t rd, input reg_idx_t rs1,
                         input reg_idx_t rs2, input bit poke_load);
        data_t a, b, r;
        int unsigned n;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'(1));
            in_valid = 1'b0;
            return;
        end
        a = model[rs1];
        b = model[rs2];
        r = op ? data_t'(a + b) : data_t'(a - b);
        @(posedge clk);
        e.res = r;
        e.z   = (r == '0);
        exp_q.push_back(e);
        n_issued++;
        model[rd] = r;
        @(negedge clk);
        chk("exec_in_ready", 32'(in_ready), 32'(0));
        chk("exec_load_ready", 32'(load_ready), 32'(0));
        chk("exec_alu_a", 32'(alu_a), 32'(a));
        chk("exec_alu_b", 32'(alu_b), 32'(b));
        chk("exec_alu_sel", 32'(alu_select), 32'(op));
        if (poke_load) begin
            load_valid = 1'b1;
            load_addr  = rd;
            load_data  = ~r;
        end
        @(negedge clk);
        chk("wb_in_ready", 32'(in_ready), 32'(0));
        chk("wb_load_ready", 32'(load_ready), 32'(0));
        load_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_op      = 1'b0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        dbg_addr   = '0;
        for (int i = 0; i < int'(NREG); i++) model[i] = '0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_zero", 32'(zero_flag), 32'(0));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        chk("rst_alu_b", 32'(alu_b), 32'(0));
        chk("rst_alu_sel", 32'(alu_select), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < int'(NREG); i++) check_reg(reg_idx_t'(i));
        @(negedge clk);

        // Add: 2 + 3 into r3
        do_load(2'd1, 4'd2);
        do_load(2'd2, 4'd3);
        issue(1'b1, 2'd3, 2'd1, 2'd2, 1'b0);
        chk("add_result", 32'(result), 32'(5));
        chk("add_zero", 32'(zero_flag), 32'(0));
        dbg_addr = 2'd3;
        #1;
        chk("add_dbg_r3", 32'(dbg_data), 32'(5));

        // Wrap to zero: 3 + 13 into r0
        do_load(2'd1, 4'd3);
        do_load(2'd2, 4'd13);
        issue(1'b1, 2'd0, 2'd1, 2'd2, 1'b0);
        chk("wrap_result", 32'(result), 32'(0));
        chk("wrap_zero", 32'(zero_flag), 32'(1));

        // Zero operands, then a nonzero add clears the flag
        do_load(2'd1, 4'd0);
        do_load(2'd2, 4'd0);
        issue(1'b1, 2'd3, 2'd1, 2'd2, 1'b0);
        chk("zeroop_result", 32'(result), 32'(0));
        chk("zeroop_zero", 32'(zero_flag), 32'(1));
        do_load(2'd1, 4'd2);
        do_load(2'd2, 4'd3);
        issue(1'b1, 2'd3, 2'd1, 2'd2, 1'b0);
        chk("zeroclr_zero", 32'(zero_flag), 32'(0));

        // Aliasing: r1 = r1 + r1 twice
        do_load(2'd1, 4'd7);
        issue(1'b1, 2'd1, 2'd1, 2'd1, 1'b0);
        dbg_addr = 2'd1;
        #1;
        chk("alias1_r1", 32'(dbg_data), 32'(14));
        issue(1'b1, 2'd1, 2'd1, 2'd1, 1'b0);
        dbg_addr = 2'd1;
        #1;
        chk("alias2_r1", 32'(dbg_data), 32'(12));

        // Load and instruction together: the load wins, the instruction sees its data
        load_valid = 1'b1;
        load_addr  = 2'd2;
        load_data  = 4'd9;
        in_valid   = 1'b1;
        in_op      = 1'b1;
        in_rd      = 2'd0;
        in_rs1     = 2'd2;
        in_rs2     = 2'd2;
        #1;
        chk("loadwin_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        model[2] = 4'd9;
        @(negedge clk);
        load_valid = 1'b0;
        chk("loadwin_no_issue", 32'(n_done), 32'(n_issued));
        issue(1'b1, 2'd0, 2'd2, 2'd2, 1'b1);
        chk("loadwin_result", 32'(result), 32'(2));
        for (int i = 0; i < int'(NREG); i++) check_reg(reg_idx_t'(i));

        // Reset in the middle of EXEC drops the instruction
        in_valid = 1'b1;
        in_op    = 1'b1;
        in_rd    = 2'd3;
        in_rs1   = 2'd0;
        in_rs2   = 2'd2;
        @(posedge clk);
        @(negedge clk);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        last_res = '0;
        last_z   = 1'b0;
        for (int i = 0; i < int'(NREG); i++) model[i] = '0;
        #1;
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < int'(NREG); i++) check_reg(reg_idx_t'(i));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_done", 32'(done), 32'(0));
        end
        chk("postrst_in_ready", 32'(in_ready), 32'(1));
        n_done   = 0;
        n_issued = 0;

        // Randomized mix of loads and instructions
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_load(reg_idx_t'($urandom_range(0, NREG - 1)), data_t'($urandom));
            end else begin
                issue(1'($urandom), reg_idx_t'($urandom_range(0, NREG - 1)),
                      reg_idx_t'($urandom_range(0, NREG - 1)),
                      reg_idx_t'($urandom_range(0, NREG - 1)), 1'($urandom));
            end
            if ($urandom_range(0, 3) == 0) check_reg(reg_idx_t'($urandom_range(0, NREG - 1)));
        end

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        chk("done_count", 32'(n_done), 32'(n_issued));
        for (int i = 0; i < int'(NREG); i++) check_reg(reg_idx_t'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
